fifo_pkt_reader: RTL and testbench
==================================

# fifo_pkt_reader

Read-side consumer for the async FIFO controller in the RGMII path. It sits in the read clock domain and waits until at least one full packet of payload words is in the FIFO. It then requests a transmit slot from the UDP TX framer and streams exactly PKT_LEN words out over a valid/ready interface. Backpressure is absorbed by a 2-entry buffer that hides the FIFO's 1-cycle read latency.

## Interface
- DATA_WIDTH, 16: FIFO word / tx_data width.
- ADDR_WIDTH, 16: FIFO address width; fifo_rdusedw is ADDR_WIDTH+1 bits.
- PKT_LEN, 64: words per packet; legal range 1..2^ADDR_WIDTH.

Ports:
- rdclk  in  1  single clock for the block.
- reset  in  1  asynchronous, active-high.
- enable  in  1  permits starting a new packet.
- fifo_rden  out  1  FIFO read strobe.
- fifo_rddata  in  DATA_WIDTH  FIFO read data, valid the cycle after fifo_rden.
- fifo_empty  in  1  FIFO empty flag.
- fifo_rdusedw  in  ADDR_WIDTH+1  FIFO fill level, read side.
- pkt_req  out  1  packet ready, requesting a TX slot.
- pkt_ack  in  1  TX framer grants the slot.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  downstream accepts the beat.
- tx_data  out  DATA_WIDTH  payload word.
- tx_last  out  1  final beat of the packet.
- pkt_done  out  1  one-cycle pulse after the last beat is accepted.
- busy  out  1  state is not IDLE.
- pkt_cnt  out  16  packets completed; wraps modulo 2^16.

## Operation
- States:
  - IDLE: go to REQ when enable && fifo_rdusedw >= PKT_LEN.
  - REQ: hold pkt_req=1 until pkt_ack is sampled high, then go to STREAM.
  - STREAM: run until the accepted-beat count reaches PKT_LEN, then go to DONE.
  - DONE: assert pkt_done for one cycle, increment pkt_cnt, return to IDLE.
- Comparison rule: fifo_rdusedw is compared unsigned, ADDR_WIDTH+1 bits wide. A stale (low) value only delays the request; it never causes over-read.
- rd_cnt: counts issued reads, 0..PKT_LEN.
- beat_cnt: counts accepted beats, 0..PKT_LEN.
- Buffer occupancy: buffered words plus in-flight reads, maximum 2.
- accept = tx_valid && tx_ready.
- fifo_rden is combinational from registered state, fifo_empty and tx_ready. It is high only when all of these hold:
  - state is STREAM;
  - fifo_empty is low;
  - rd_cnt < PKT_LEN;
  - occupancy − accept < 2.
- fifo_rden is never asserted while fifo_empty is high.
- Data path:
  - fifo_rddata is captured into the buffer the cycle after fifo_rden.
  - tx_data/tx_valid are driven from the buffer head register, which is FIFO-ordered.
  - tx_data is held stable while tx_valid && !tx_ready.
- tx_last = tx_valid && (beat_cnt == PKT_LEN−1).
- enable deasserted mid-packet: the current packet completes; no new request is made.
- pkt_ack outside REQ is ignored.

## Timing
- Reset values (asynchronous, immediate): state IDLE, and all outputs 0 (fifo_rden, pkt_req, tx_valid, tx_data, tx_last, pkt_done, busy, pkt_cnt, counters).
- Request latency: pkt_req rises the cycle after the IDLE condition is sampled true.
- Stream start: pkt_ack sampled at edge N gives the first fifo_rden in cycle N+1 and the first tx_valid in cycle N+3.
- Throughput: 1 word/cycle sustained while tx_ready=1 and FIFO not empty.
- Packet end: the last beat is accepted at edge M, pkt_done is high in cycle M+1, and pkt_cnt has incremented by cycle M+2.
- Reset mid-packet: words already read are discarded. The FIFO controller is expected to share the same reset.

## Structure
- Shared package fifo_rd_pkg holds:
  - state enum (IDLE, REQ, STREAM, DONE);
  - BUF_DEPTH=2 constant.
- One sub-module, skid_buf2: 2-entry data buffer with push/pop and an occupancy output, in-flight count tracked by the parent.

## Test plan
- PKT_LEN=4, FIFO preloaded 0x0001..0x0004, rdusedw=4, enable=1, tx_ready=1, pkt_ack one cycle after pkt_req -> tx_data 1,2,3,4 on consecutive cycles starting 3 cycles after ack; tx_last on 0x0004; pkt_done pulse; pkt_cnt=1; exactly 4 rden.
- Same setup with tx_ready alternating 1/0 -> same 4 words in order, no duplicates, tx_data stable while stalled, rden never with occupancy ≥2.
- rdusedw=3 held for 20 cycles -> pkt_req stays 0; rdusedw=4 -> pkt_req=1 next cycle.
- fifo_empty forced high for 5 cycles mid-stream -> no rden during those cycles, tx_valid drops after the buffer drains, stream resumes in order.
- reset asserted while beat 2 is valid -> all outputs 0 in the same cycle, busy=0, pkt_cnt=0; after release no tx_valid until a new request/ack.
- PKT_LEN=1, one word 0xABCD -> single beat with tx_last=1, pkt_done the following cycle.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared FSM encoding and buffer sizing for fifo_pkt_reader
//
// Contents:
//   rd_state_e          reader FSM states (IDLE, REQ, STREAM, DONE)
//   ST_* localparams    the same encodings as plain logic [1:0] constants
//   BUF_DEPTH, OCC_W    skid buffer depth and occupancy counter width
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } rd_state_e;

  localparam logic [1:0] ST_IDLE   = IDLE;
  localparam logic [1:0] ST_REQ    = REQ;
  localparam logic [1:0] ST_STREAM = STREAM;
  localparam logic [1:0] ST_DONE   = DONE;

  localparam int BUF_DEPTH = 2;
  localparam int OCC_W     = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// rtl/fifo_pkt_reader_if.sv - FIFO, TX-slot and stream signals of fifo_pkt_reader
//
// master: the reader (drives fifo_rden, pkt_req, tx_*, pkt_done, busy, pkt_cnt)
// slave : its environment (FIFO controller, UDP TX framer, stream sink)
interface fifo_pkt_reader_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16
);
  logic                  enable;
  logic                  fifo_rden;
  logic [DATA_WIDTH-1:0] fifo_rddata;
  logic                  fifo_empty;
  logic [ADDR_WIDTH:0]   fifo_rdusedw;
  logic                  pkt_req;
  logic                  pkt_ack;
  logic                  tx_valid;
  logic                  tx_ready;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_last;
  logic                  pkt_done;
  logic                  busy;
  logic [15:0]           pkt_cnt;

  modport master (
    input  enable, fifo_rddata, fifo_empty, fifo_rdusedw, pkt_ack, tx_ready,
    output fifo_rden, pkt_req, tx_valid, tx_data, tx_last, pkt_done, busy, pkt_cnt
  );

  modport slave (
    output enable, fifo_rddata, fifo_empty, fifo_rdusedw, pkt_ack, tx_ready,
    input  fifo_rden, pkt_req, tx_valid, tx_data, tx_last, pkt_done, busy, pkt_cnt
  );
endinterface

// File: rtl/fifo_pkt_reader_skid_buf2.sv
// rtl/fifo_pkt_reader_skid_buf2.sv - 2-entry FIFO-ordered data buffer
//
// Ports:
//   rdclk, reset  clock, asynchronous active-high reset
//   push          write push_data this edge
//   push_data     word to store
//   pop           head word consumed this edge
//   head_data     oldest stored word (held while not popped)
//   count         stored words, 0..BUF_DEPTH
// The parent guarantees no push when full without a simultaneous pop.
module skid_buf2
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  rdclk,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head_data,
  output logic [OCC_W-1:0]      count
);

  logic [DATA_WIDTH-1:0] tail_q;

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      head_data <= '0;
      tail_q    <= '0;
      count     <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == '0) head_data <= push_data;
          else             tail_q    <= push_data;
          count <= count + OCC_W'(1);
        end
        2'b01: begin
          head_data <= tail_q;
          count     <= count - OCC_W'(1);
        end
        2'b11: begin
          // Count is unchanged; the new word goes behind whatever remains.
          if (count == OCC_W'(1)) begin
            head_data <= push_data;
          end else begin
            head_data <= tail_q;
            tail_q    <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_pkt_reader.sv
// rtl/fifo_pkt_reader.sv - read-side packet streamer for the RGMII async FIFO
//
// Waits for a full packet in the FIFO, requests a TX slot, then streams
// PKT_LEN words over a valid/ready interface.
// Ports:
//   rdclk  read-domain clock
//   reset  asynchronous active-high reset
//   bus    fifo_pkt_reader_if.master: enable, fifo_rden/rddata/empty/rdusedw,
//          pkt_req/pkt_ack, tx_valid/ready/data/last, pkt_done, busy, pkt_cnt
module fifo_pkt_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int PKT_LEN    = 64
) (
  input logic               rdclk,
  input logic               reset,
  fifo_pkt_reader_if.master bus
);

  localparam int                CNT_W  = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0]  LEN    = CNT_W'(PKT_LEN);
  localparam logic [CNT_W-1:0]  LEN_M1 = CNT_W'(PKT_LEN - 1);

  logic [1:0]            state_q;
  logic [CNT_W-1:0]      rd_cnt_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic                  inflight_q;
  logic [15:0]           pkt_cnt_q;
  logic [OCC_W-1:0]      buf_cnt;
  logic [DATA_WIDTH-1:0] head_data;
  logic [OCC_W-1:0]      occ_after;
  logic                  accept;
  logic                  rden;

  assign bus.tx_valid = (buf_cnt != '0);
  assign bus.tx_data  = head_data;
  assign accept       = bus.tx_valid && bus.tx_ready;

  // Words owned by this block after this edge: buffered plus the read still
  // in flight, minus the beat leaving now. Never exceeds the buffer depth.
  assign occ_after = buf_cnt + OCC_W'(inflight_q) - OCC_W'(accept);

  assign rden = (state_q == ST_STREAM) && !bus.fifo_empty &&
                (rd_cnt_q < LEN) && (occ_after < OCC_W'(BUF_DEPTH));

  assign bus.fifo_rden = rden;
  assign bus.tx_last   = bus.tx_valid && (beat_cnt_q == LEN_M1);
  assign bus.pkt_req   = (state_q == ST_REQ);
  assign bus.pkt_done  = (state_q == ST_DONE);
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.pkt_cnt   = pkt_cnt_q;

  always_ff @(posedge rdclk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_cnt_q   <= '0;
      beat_cnt_q <= '0;
      inflight_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      inflight_q <= rden;
      if (rden)   rd_cnt_q   <= rd_cnt_q + CNT_W'(1);
      if (accept) beat_cnt_q <= beat_cnt_q + CNT_W'(1);
      case (state_q)
        ST_IDLE: begin
          if (bus.enable && (bus.fifo_rdusedw >= LEN)) state_q <= ST_REQ;
        end
        ST_REQ: begin
          // Buffer is empty here, so the counters can restart safely.
          if (bus.pkt_ack) begin
            state_q    <= ST_STREAM;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
          end
        end
        ST_STREAM: begin
          if (accept && (beat_cnt_q == LEN_M1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          state_q   <= ST_IDLE;
          pkt_cnt_q <= pkt_cnt_q + 16'd1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  skid_buf2 #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .rdclk    (rdclk),
    .reset    (reset),
    .push     (inflight_q),
    .push_data(bus.fifo_rddata),
    .pop      (accept),
    .head_data(head_data),
    .count    (buf_cnt)
  );

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// tb/tb_fifo_pkt_reader.sv - randomized self-checking bench for fifo_pkt_reader
module tb_fifo_pkt_reader;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int UW = AW + 1;

  logic rdclk = 1'b0;
  logic reset = 1'b1;
  always #5 rdclk = ~rdclk;

  fifo_pkt_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if4 ();
  fifo_pkt_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) if1 ();

  fifo_pkt_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_LEN(4)) dut4 (
    .rdclk(rdclk), .reset(reset), .bus(if4.master));
  fifo_pkt_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PKT_LEN(1)) dut1 (
    .rdclk(rdclk), .reset(reset), .bus(if1.master));

  logic          sel1, enable, pkt_ack, tx_ready, force_empty, use_override, empty;
  logic [DW-1:0] rddata;
  logic [UW-1:0] override_used, usedw;
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];
  logic [15:0]   exp_cnt[2];
  int            errors = 0;
  int            checks = 0;

  assign if4.enable = enable && !sel1;
  assign if1.enable = enable && sel1;
  assign if4.fifo_rddata = rddata;   assign if1.fifo_rddata = rddata;
  assign if4.fifo_empty = empty;     assign if1.fifo_empty = empty;
  assign if4.fifo_rdusedw = usedw;   assign if1.fifo_rdusedw = usedw;
  assign if4.pkt_ack = pkt_ack;      assign if1.pkt_ack = pkt_ack;
  assign if4.tx_ready = tx_ready;    assign if1.tx_ready = tx_ready;

  logic          m_rden, m_req, m_valid, m_last, m_done, m_busy;
  logic [DW-1:0] m_data;
  logic [15:0]   m_cnt;
  assign m_rden  = sel1 ? if1.fifo_rden : if4.fifo_rden;
  assign m_req   = sel1 ? if1.pkt_req   : if4.pkt_req;
  assign m_valid = sel1 ? if1.tx_valid  : if4.tx_valid;
  assign m_last  = sel1 ? if1.tx_last   : if4.tx_last;
  assign m_done  = sel1 ? if1.pkt_done  : if4.pkt_done;
  assign m_busy  = sel1 ? if1.busy      : if4.busy;
  assign m_data  = sel1 ? if1.tx_data   : if4.tx_data;
  assign m_cnt   = sel1 ? if1.pkt_cnt   : if4.pkt_cnt;

  task automatic update_flags();
    empty = force_empty || (fifo_q.size() == 0);
    usedw = use_override ? override_used : UW'(fifo_q.size());
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    update_flags();
  endtask

  task automatic sample();
    #3;
  endtask

  // FIFO model: a read strobed this cycle shows its word on rddata next cycle.
  task automatic advance();
    logic rd;
    rd = m_rden;
    @(posedge rdclk);
    #1;
    if (rd && fifo_q.size() > 0) rddata = fifo_q.pop_front();
    update_flags();
  endtask

  // mode 0: ready=1; mode 1: ready alternates; mode 2: random ready/empty/ack
  task automatic run_stream(input int len, input int mode, input int empty_at);
    int c, a_cyc, first_rd, first_v, done_cyc, reads, beats, req_cnt, ack_dly, idx;
    logic stall_prev, acc, fin;
    logic [DW-1:0] data_prev;
    idx = sel1 ? 1 : 0;
    a_cyc = -1; first_rd = -1; first_v = -1; done_cyc = -1;
    reads = 0; beats = 0; req_cnt = 0; stall_prev = 0; data_prev = '0; fin = 0;
    ack_dly = (mode == 2) ? int'($urandom_range(0, 3)) : 0;
    enable = 1'b1;
    c = 0;
    while (!fin && c < 300) begin
      tx_ready = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      force_empty = (empty_at >= 0 && c >= empty_at && c < empty_at + 5) ||
                    (mode == 2 && $urandom_range(0, 7) == 0);
      update_flags();
      pkt_ack = (req_cnt == ack_dly + 1) || (mode == 2 && a_cyc >= 0 && $urandom_range(0, 3) == 0);
      sample();
      if (m_req) req_cnt++; else req_cnt = 0;
      if (pkt_ack && m_req && a_cyc < 0) a_cyc = c;
      if (m_rden && first_rd < 0) first_rd = c;
      if (m_valid && first_v < 0) first_v = c;
      acc = m_valid && tx_ready;
      if (m_rden) begin
        checks++;
        if (empty) begin
          errors++; $display("FAIL rden_empty: cycle %0d rden=1 while fifo_empty=1", c);
        end
        checks++;
        if ((reads - beats - (acc ? 1 : 0)) >= 2 || reads >= len) begin
          errors++; $display("FAIL rden_occ: cycle %0d reads=%0d accepted=%0d len=%0d", c, reads, beats, len);
        end
        reads++;
      end
      if (stall_prev) begin
        checks++;
        if (m_valid !== 1'b1 || m_data !== data_prev) begin
          errors++; $display("FAIL stall_hold: valid=%b data=%h required valid=1 data=%h", m_valid, m_data, data_prev);
        end
      end
      if (m_valid) begin
        checks++;
        if (m_last !== ((beats == len - 1) ? 1'b1 : 1'b0)) begin
          errors++; $display("FAIL tx_last: got %b at beat %0d of %0d", m_last, beats, len);
        end
      end
      if (acc) begin
        checks++;
        if (exp_q.size() == 0 || m_data !== exp_q[0]) begin
          errors++; $display("FAIL tx_data: got %h expected %h", m_data, (exp_q.size() > 0) ? exp_q[0] : 16'hxxxx);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        beats++;
        if (beats == len) done_cyc = c + 1;
      end
      checks++;
      if (m_done !== ((c == done_cyc) ? 1'b1 : 1'b0)) begin
        errors++; $display("FAIL pkt_done: cycle %0d got %b (done expected at %0d)", c, m_done, done_cyc);
      end
      if (c == done_cyc) begin
        checks++;
        if (m_cnt !== exp_cnt[idx]) begin
          errors++; $display("FAIL pkt_cnt_early: got %0d expected %0d", m_cnt, exp_cnt[idx]);
        end
      end
      if (empty_at >= 0 && c == empty_at + 4) begin
        checks++;
        if (m_valid !== 1'b0) begin
          errors++; $display("FAIL drain: tx_valid=%b expected 0 after buffer drains", m_valid);
        end
      end
      stall_prev = m_valid && !tx_ready;
      data_prev  = m_data;
      if (done_cyc >= 0 && c == done_cyc + 1) begin
        fin = 1;
        exp_cnt[idx] = exp_cnt[idx] + 16'd1;
        checks++;
        if (m_cnt !== exp_cnt[idx] || m_busy !== 1'b0) begin
          errors++; $display("FAIL pkt_end: pkt_cnt=%0d busy=%b expected %0d busy=0", m_cnt, m_busy, exp_cnt[idx]);
        end
        checks++;
        if (reads != len) begin
          errors++; $display("FAIL rden_count: got %0d expected %0d", reads, len);
        end
        if (mode != 2) begin
          checks++;
          if (first_rd != a_cyc + 1 || first_v != a_cyc + 3) begin
            errors++; $display("FAIL start_lat: ack@%0d rden@%0d valid@%0d expected %0d/%0d",
                               a_cyc, first_rd, first_v, a_cyc + 1, a_cyc + 3);
          end
        end
        if (mode == 0 && empty_at < 0) begin
          checks++;
          if (done_cyc != a_cyc + 3 + len) begin
            errors++; $display("FAIL throughput: done@%0d expected %0d", done_cyc, a_cyc + 3 + len);
          end
        end
      end
      advance();
      c++;
    end
    if (!fin) begin
      checks++; errors++;
      $display("FAIL timeout: packet not completed, accepted %0d of %0d", beats, len);
    end
    enable = 1'b0; pkt_ack = 1'b0; force_empty = 1'b0; update_flags();
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({m_rden, m_req, m_valid, m_last, m_done, m_busy, m_data, m_cnt, if1.busy} !== '0) begin
      errors++; $display("FAIL reset_state: outputs not all zero (valid=%b busy=%b data=%h cnt=%0d)",
                         m_valid, m_busy, m_data, m_cnt);
    end
    @(posedge rdclk); @(posedge rdclk); #1;
    reset = 1'b0;
    update_flags();
  endtask

  task automatic test_basic();
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    run_stream(4, 0, -1);
  endtask

  task automatic test_backpressure();
    for (int i = 1; i <= 4; i++) push_word(DW'(i));
    run_stream(4, 1, -1);
  endtask

  task automatic test_threshold();
    for (int i = 0; i < 4; i++) push_word(DW'(16'h0A00 + i));
    use_override = 1'b1; override_used = UW'(3); enable = 1'b1; update_flags();
    for (int i = 0; i < 20; i++) begin
      sample();
      checks++;
      if (m_req !== 1'b0) begin
        errors++; $display("FAIL threshold_low: pkt_req=%b with rdusedw=3", m_req);
      end
      advance();
    end
    override_used = UW'(4); update_flags();
    sample();
    checks++;
    if (m_req !== 1'b0) begin
      errors++; $display("FAIL req_latency0: pkt_req=%b in the cycle rdusedw reaches 4", m_req);
    end
    advance();
    sample();
    checks++;
    if (m_req !== 1'b1) begin
      errors++; $display("FAIL req_latency1: pkt_req=%b expected 1", m_req);
    end
    advance();
    use_override = 1'b0; update_flags();
    run_stream(4, 0, -1);
  endtask

  task automatic test_empty_stall();
    for (int i = 0; i < 4; i++) push_word(DW'(16'h0E10 + i));
    run_stream(4, 0, 4);
  endtask

  task automatic test_reset_mid();
    int beats;
    logic hit, req_prev;
    for (int i = 0; i < 4; i++) push_word(DW'(16'h0100 + i));
    enable = 1'b1; tx_ready = 1'b1; beats = 0; hit = 0; req_prev = 0;
    for (int c = 0; c < 30 && !hit; c++) begin
      pkt_ack = req_prev;
      sample();
      req_prev = m_req;
      if (m_valid && beats == 1) begin
        hit = 1;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({m_rden, m_req, m_valid, m_last, m_done, m_busy} !== 6'b0) begin
          errors++; $display("FAIL reset_flags: rden/req/valid/last/done/busy=%b expected 0",
                             {m_rden, m_req, m_valid, m_last, m_done, m_busy});
        end
        checks++;
        if (m_data !== '0 || m_cnt !== 16'd0) begin
          errors++; $display("FAIL reset_regs: tx_data=%h pkt_cnt=%0d expected 0", m_data, m_cnt);
        end
      end else begin
        if (m_valid && tx_ready) beats++;
        advance();
      end
    end
    if (!hit) begin
      checks++; errors++; $display("FAIL reset_timeout: beat 2 never became valid");
    end
    fifo_q.delete(); exp_q.delete();
    exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0;
    enable = 1'b0; pkt_ack = 1'b0; update_flags();
    @(posedge rdclk); @(posedge rdclk); #1;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) push_word(DW'(16'h0200 + i));
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++;
      if (m_valid !== 1'b0 || m_busy !== 1'b0) begin
        errors++; $display("FAIL post_reset: tx_valid=%b busy=%b expected 0", m_valid, m_busy);
      end
      advance();
    end
    run_stream(4, 0, -1);
  endtask

  task automatic test_len1();
    sel1 = 1'b1;
    push_word(16'hABCD);
    run_stream(1, 0, -1);
    sel1 = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 24; i++) push_word(DW'($urandom));
    for (int p = 0; p < 6; p++) run_stream(4, 2, -1);
  endtask

  initial begin
    sel1 = 1'b0; enable = 1'b0; pkt_ack = 1'b0; tx_ready = 1'b0; force_empty = 1'b0;
    use_override = 1'b0; override_used = '0; rddata = '0;
    exp_cnt[0] = 16'd0; exp_cnt[1] = 16'd0;
    update_flags();
    test_reset();
    test_basic();
    test_backpressure();
    test_threshold();
    test_empty_stall();
    test_reset_mid();
    test_len1();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
